// File: rtl/buff_uart_host_if.sv
// rtl/buff_uart_host_if.sv - peripheral bus and byte-stream signals of buff_uart_host
interface buff_uart_host_if #(
  parameter int width         = 8,
  parameter int address_width = 4
);
  logic [address_width-1:0] active_address;
  logic                     read_enable;
  logic                     write_enable;
  logic [width-1:0]         bus_data_out;
  logic [width-1:0]         bus_data_in;
  logic [width-1:0]         s_data;
  logic                     s_valid;
  logic                     s_ready;
  logic [width-1:0]         m_data;
  logic                     m_valid;
  logic                     m_ready;

  modport master (
    output active_address, read_enable, write_enable, bus_data_out, s_ready, m_data, m_valid,
    input  bus_data_in, s_data, s_valid, m_ready
  );

  modport slave (
    input  active_address, read_enable, write_enable, bus_data_out, s_ready, m_data, m_valid,
    output bus_data_in, s_data, s_valid, m_ready
  );
endinterface

// File: rtl/buff_uart_host.sv
// rtl/buff_uart_host.sv - status-polling bus initiator for the buffered UART
// BUFF_UART_HOST_STATS_EN adds rx_count, tx_count and sticky overrun outputs.
module buff_uart_host #(
  parameter int width          = 8,
  parameter int address_width  = 4,
  parameter int rx_address     = 1,
  parameter int tx_address     = 2,
  parameter int status_address = 3,
  parameter int poll_interval  = 16
) (
  input  logic             clock,
  input  logic             reset,
  buff_uart_host_if.master bus
`ifdef BUFF_UART_HOST_STATS_EN
  ,
  output logic [15:0]      rx_count,
  output logic [15:0]      tx_count,
  output logic             overrun
`endif
);
  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] ST_REQ  = 3'd1;
  localparam logic [2:0] ST_CAP  = 3'd2;
  localparam logic [2:0] RX_REQ  = 3'd3;
  localparam logic [2:0] RX_CAP  = 3'd4;
  localparam logic [2:0] TX_PUSH = 3'd5;

  localparam int                       cnt_w       = (poll_interval > 1) ? $clog2(poll_interval) : 1;
  localparam logic [cnt_w-1:0]         poll_last   = cnt_w'(poll_interval - 1);
  localparam logic [address_width-1:0] rx_addr     = address_width'(rx_address);
  localparam logic [address_width-1:0] tx_addr     = address_width'(tx_address);
  localparam logic [address_width-1:0] status_addr = address_width'(status_address);

  logic [2:0]               state;
  logic [cnt_w-1:0]         poll_cnt;
  logic                     repoll;
  logic                     prio_tx;
  logic [address_width-1:0] address_q;
  logic [width-1:0]         data_out_q;
  logic [width-1:0]         m_data_q;
  logic                     m_valid_q;
  logic                     rx_empty;
  logic                     tx_full;
  logic                     rx_ok;
  logic                     tx_ok;
  logic                     take_rx;

  // status word is only meaningful in ST_CAP, one cycle after the status strobe
  assign rx_empty = bus.bus_data_in[3];
  assign tx_full  = bus.bus_data_in[0];
  assign rx_ok    = !rx_empty && !m_valid_q;
  assign tx_ok    = !tx_full && bus.s_valid;
  assign take_rx  = rx_ok && (!tx_ok || !prio_tx);

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= IDLE;
      poll_cnt   <= '0;
      repoll     <= 1'b0;
      prio_tx    <= 1'b0;
      address_q  <= '0;
      data_out_q <= '0;
      m_data_q   <= '0;
      m_valid_q  <= 1'b0;
    end else begin
      if (m_valid_q && bus.m_ready) m_valid_q <= 1'b0;
      case (state)
        IDLE: begin
          if (repoll || poll_cnt == poll_last) begin
            state     <= ST_REQ;
            poll_cnt  <= '0;
            repoll    <= 1'b0;
            address_q <= status_addr;
          end else begin
            poll_cnt <= poll_cnt + cnt_w'(1);
          end
        end
        ST_REQ: state <= ST_CAP;
        ST_CAP: begin
          if (rx_ok && tx_ok) prio_tx <= !prio_tx;
          if (take_rx) begin
            state     <= RX_REQ;
            address_q <= rx_addr;
          end else if (tx_ok) begin
            state      <= TX_PUSH;
            address_q  <= tx_addr;
            data_out_q <= bus.s_data;
          end else begin
            state <= IDLE;
          end
        end
        RX_REQ: state <= RX_CAP;
        RX_CAP: begin
          m_data_q  <= bus.bus_data_in;
          m_valid_q <= 1'b1;
          repoll    <= 1'b1;
          state     <= IDLE;
        end
        TX_PUSH: begin
          repoll <= 1'b1;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.active_address = address_q;
  assign bus.write_enable   = (state == ST_REQ) || (state == RX_REQ);
  assign bus.read_enable    = (state == TX_PUSH);
  assign bus.s_ready        = (state == TX_PUSH);
  assign bus.bus_data_out   = data_out_q;
  assign bus.m_data         = m_data_q;
  assign bus.m_valid        = m_valid_q;

`ifdef BUFF_UART_HOST_STATS_EN
  always_ff @(posedge clock) begin
    if (reset) begin
      rx_count <= 16'd0;
      tx_count <= 16'd0;
      overrun  <= 1'b0;
    end else begin
      if (state == RX_CAP)  rx_count <= rx_count + 16'd1;
      if (state == TX_PUSH) tx_count <= tx_count + 16'd1;
      if (state == ST_CAP && bus.bus_data_in[2]) overrun <= 1'b1;
    end
  end
`endif
endmodule

// File: tb/tb_buff_uart_host.sv
// tb/tb_buff_uart_host.sv - directed bench for buff_uart_host with a schedule-based reference model
module tb_buff_uart_host;
  localparam int         POLL     = 16;
  localparam logic [3:0] RX_A     = 4'd1;
  localparam logic [3:0] TX_A     = 4'd2;
  localparam logic [3:0] STATUS_A = 4'd3;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  buff_uart_host_if #(.width(8), .address_width(4)) bus_if ();

`ifdef BUFF_UART_HOST_STATS_EN
  logic [15:0] rx_count;
  logic [15:0] tx_count;
  logic        overrun;
`endif

  buff_uart_host #(
    .width(8), .address_width(4), .rx_address(1), .tx_address(2),
    .status_address(3), .poll_interval(POLL)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus(bus_if.master)
`ifdef BUFF_UART_HOST_STATS_EN
    ,
    .rx_count(rx_count),
    .tx_count(tx_count),
    .overrun(overrun)
`endif
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // peripheral and source stimulus state
  logic [3:0] default_status = 4'b1010;
  logic [3:0] status_q[$];
  logic [7:0] rx_bytes[5] = '{8'hEE, 8'hA5, 8'h5A, 8'h66, 8'h77};
  int         rx_idx = 0;
  logic [7:0] tx_bytes[3] = '{8'h3C, 8'h11, 8'h22};
  int         tx_n = 0;
  int         tx_sent = 0;
  string      log_s = "";
  logic [7:0] push_log[$];

  // peripheral: registered response one cycle after each strobe, junk in the upper status nibble
  initial begin
    logic       we, re;
    logic [3:0] a;
    logic [7:0] d;
    bus_if.bus_data_in = 8'h00;
    forever begin
      @(negedge clock);
      we = bus_if.write_enable; re = bus_if.read_enable;
      a  = bus_if.active_address; d = bus_if.bus_data_out;
      @(posedge clock); #1;
      if (we && a == STATUS_A) begin
        if (status_q.size() > 0) bus_if.bus_data_in = {4'hF, status_q.pop_front()};
        else                     bus_if.bus_data_in = {4'hF, default_status};
      end else if (we && a == RX_A) begin
        bus_if.bus_data_in = rx_bytes[rx_idx];
        rx_idx++;
        log_s = {log_s, "R"};
      end else begin
        bus_if.bus_data_in = 8'hC3;
      end
      if (re && a == TX_A) begin
        log_s = {log_s, "T"};
        push_log.push_back(d);
      end
    end
  end

  // byte source: holds each byte until it sees s_ready
  initial begin
    logic hs;
    bus_if.s_valid = 1'b0;
    bus_if.s_data  = 8'h00;
    forever begin
      @(negedge clock);
      hs = bus_if.s_ready;
      @(posedge clock); #1;
      if (hs) tx_sent++;
      bus_if.s_valid = (tx_sent < tx_n);
      bus_if.s_data  = (tx_sent < tx_n) ? tx_bytes[tx_sent] : 8'h00;
    end
  end

  // reference model: schedules the cycle numbers of polls and transfers
  bit         model_on = 1'b0;
  int         cyc, next_poll, rx_at, push_at;
  bit         prio_tx, exp_mv;
  logic [7:0] exp_md, exp_push;

  function automatic void model_reset();
    cyc = 0; next_poll = POLL; rx_at = -10; push_at = -10;
    prio_tx = 1'b0; exp_mv = 1'b0; exp_md = 8'h00; exp_push = 8'h00;
  endfunction

  always @(negedge clock) begin
    if (model_on) begin
      bit rx_ok, tx_ok;
      check("write_enable", 32'(bus_if.write_enable), 32'((cyc == next_poll) || (cyc == rx_at)));
      check("read_enable", 32'(bus_if.read_enable), 32'(cyc == push_at));
      check("s_ready", 32'(bus_if.s_ready), 32'(cyc == push_at));
      if (cyc == next_poll || cyc == next_poll + 1)
        check("status_address", 32'(bus_if.active_address), 32'(STATUS_A));
      if (cyc == rx_at || cyc == rx_at + 1)
        check("rx_address", 32'(bus_if.active_address), 32'(RX_A));
      if (cyc == push_at) begin
        check("tx_address", 32'(bus_if.active_address), 32'(TX_A));
        check("push_data", 32'(bus_if.bus_data_out), 32'(exp_push));
      end
      check("m_valid", 32'(bus_if.m_valid), 32'(exp_mv));
      if (exp_mv) check("m_data", 32'(bus_if.m_data), 32'(exp_md));
      if (cyc == next_poll + 1) begin
        rx_ok = !bus_if.bus_data_in[3] && !exp_mv;
        tx_ok = !bus_if.bus_data_in[0] && bus_if.s_valid;
        if (rx_ok && (!tx_ok || !prio_tx)) begin
          rx_at = cyc + 1; next_poll = cyc + 4;
        end else if (tx_ok) begin
          push_at = cyc + 1; exp_push = bus_if.s_data; next_poll = cyc + 3;
        end else begin
          next_poll = cyc + 1 + POLL;
        end
        if (rx_ok && tx_ok) prio_tx = !prio_tx;
      end
      if (exp_mv && bus_if.m_ready) exp_mv = 1'b0;
      if (cyc == rx_at + 1) begin
        exp_mv = 1'b1; exp_md = bus_if.bus_data_in;
      end
      cyc++;
    end
  end

  task automatic tick(input int n);
    repeat (n) begin @(posedge clock); #1; end
  endtask

  task automatic wait_strobe(input bit we, input logic [3:0] addr, input string name);
    int n = 0;
    do begin
      @(negedge clock); n++;
    end while (!((we ? bus_if.write_enable : bus_if.read_enable) && bus_if.active_address == addr) && n < 200);
    check({name, "_timeout"}, 32'(n < 200), 32'd1);
  endtask

  task automatic wait_quiet();
    wait_strobe(1'b1, STATUS_A, "quiet");
    tick(3);
  endtask

  task automatic wait_log(input int len, input string name);
    int n = 0;
    while (log_s.len() < len && n < 400) begin tick(1); n++; end
    check({name, "_timeout"}, 32'(log_s.len() >= len), 32'd1);
  endtask

  task automatic measure_first_poll(output int n);
    n = 0;
    @(negedge clock);
    while (!bus_if.write_enable && n < 100) begin n++; @(negedge clock); end
  endtask

  initial begin
    int n;
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    bus_if.m_ready = 1'b1;
    tick(2);
    check("rst_write_enable", 32'(bus_if.write_enable), 32'd0);
    check("rst_read_enable", 32'(bus_if.read_enable), 32'd0);
    check("rst_s_ready", 32'(bus_if.s_ready), 32'd0);
    check("rst_m_valid", 32'(bus_if.m_valid), 32'd0);
    check("rst_address", 32'(bus_if.active_address), 32'd0);
    check("rst_bus_data_out", 32'(bus_if.bus_data_out), 32'd0);
    check("rst_m_data", 32'(bus_if.m_data), 32'd0);
    reset = 1'b0; model_reset(); model_on = 1'b1;
    measure_first_poll(n);
    check("first_poll_cycle", 32'(n), 32'd16);
    tick(3);

    // reset held three cycles while an RX fetch strobe is on the bus
    default_status = 4'b0010;
    wait_strobe(1'b1, RX_A, "rx_req_for_reset");
    model_on = 1'b0; reset = 1'b1;
    tick(1);
    check("rstmid_write_enable", 32'(bus_if.write_enable), 32'd0);
    check("rstmid_m_valid", 32'(bus_if.m_valid), 32'd0);
    tick(2);
    check("rstmid_address", 32'(bus_if.active_address), 32'd0);
    default_status = 4'b1010;
    reset = 1'b0; model_reset(); model_on = 1'b1; log_s = "";
`ifdef BUFF_UART_HOST_STATS_EN
    check("stats_rx_zero", 32'(rx_count), 32'd0);
    check("stats_ov_zero", 32'(overrun), 32'd0);
`endif
    measure_first_poll(n);
    check("first_poll_after_reset", 32'(n), 32'd16);
    tick(3);

    // single RX byte, sink always ready
    status_q.push_back(4'b0101);
    n = 0;
    do begin @(negedge clock); n++; end while (!bus_if.m_valid && n < 200);
    check("rx_mvalid_timeout", 32'(n < 200), 32'd1);
    check("rx_data_a5", 32'(bus_if.m_data), 32'hA5);
    @(negedge clock);
    check("rx_mvalid_one_cycle", 32'(bus_if.m_valid), 32'd0);
    wait_quiet();

    // single TX byte
    tx_n = 1;
    wait_log(2, "tx_push");
    check("tx_push_3c", 32'(push_log[0]), 32'h3C);
    wait_quiet();

    // both directions ready: service alternates
    repeat (4) status_q.push_back(4'b0100);
    tx_n = 3;
    wait_log(6, "alternate");
    wait_quiet();
    check("alt_push_1", 32'(push_log[1]), 32'h11);
    check("alt_push_2", 32'(push_log[2]), 32'h22);

    // sink stalled: one fetch, then polls only
    bus_if.m_ready = 1'b0;
    default_status = 4'b0010;
    tick(60);
    checks++;
    if (log_s != "RTRTRTR") begin
      errors++;
      $display("FAIL transfer_order: got %s expected RTRTRTR", log_s);
    end
    check("stall_m_valid", 32'(bus_if.m_valid), 32'd1);
    check("stall_m_data", 32'(bus_if.m_data), 32'h77);
    wait_quiet();
    default_status = 4'b1010;
    bus_if.m_ready = 1'b1;
    tick(1);
    @(negedge clock);
    check("release_m_valid", 32'(bus_if.m_valid), 32'd0);
`ifdef BUFF_UART_HOST_STATS_EN
    check("stats_rx_count", 32'(rx_count), 32'd4);
    check("stats_tx_count", 32'(tx_count), 32'd3);
    check("stats_overrun", 32'(overrun), 32'd1);
`endif
    tick(20);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
